// File: rtl/mult_4x4.sv
// mult_4x4: sequential 4x4 unsigned shift-and-add multiplier with start/done handshake
module mult_4x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       St,
    input  logic [3:0] Mplier,
    input  logic [3:0] Mcand,
    output logic       Done,
    output logic [8:0] ACC
);
    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [3:0] mcand_r;
    logic [2:0] cnt;
    // next-state and Moore output decode; Done depends on state only
    always_comb begin
        state_n = (state == IDLE)  ? (St ? ADD : IDLE) :
                  (state == ADD)   ? SHIFT :
                  (state == SHIFT) ? ((cnt == 3'd3) ? DONE : ADD) : IDLE;
        Done = (state == DONE);
    end
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // datapath: load, conditional add into upper half, shift right, count iterations
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ACC <= '0;
            mcand_r <= '0;
            cnt <= '0;
        end else if (state == IDLE && St) begin
            ACC <= {5'b0, Mplier};
            mcand_r <= Mcand;
            cnt <= '0;
        end else if (state == ADD && ACC[0]) begin
            ACC[8:4] <= {1'b0, ACC[7:4]} + {1'b0, mcand_r};
        end else if (state == SHIFT) begin
            ACC <= {1'b0, ACC[8:1]};
            cnt <= cnt + 3'd1;
        end
endmodule

// File: tb/tb_mult_4x4.sv
// tb_mult_4x4: directed self-checking bench for mult_4x4
module tb_mult_4x4;
    logic       clk = 0;
    logic       rst = 1;
    logic       St = 0;
    logic [3:0] Mplier = 0;
    logic [3:0] Mcand = 0;
    logic       Done;
    logic [8:0] ACC;
    int checks = 0;
    int fails = 0;

    mult_4x4 dut (.clk(clk), .rst(rst), .St(St), .Mplier(Mplier), .Mcand(Mcand), .Done(Done), .ACC(ACC));

    always #5 clk = ~clk;

    // Start one multiply from a negedge, return with the edge count to Done, ACC at Done,
    // and Done one cycle later (the bench is left at an IDLE negedge).
    task automatic mult_run(input logic [3:0] a, input logic [3:0] b,
                            output int lat, output logic [8:0] acc, output logic done_after);
        Mplier = a; Mcand = b; St = 1;
        @(negedge clk); St = 0; lat = 1;
        while (!Done && lat < 20) begin @(negedge clk); lat++; end
        acc = ACC;
        @(negedge clk);
        done_after = Done;
    endtask

    task automatic test_reset;
        checks++; if (ACC !== 9'd0) begin fails++; $display("FAIL reset_acc: got %0d want 0", ACC); end
        checks++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", Done); end
        @(negedge clk); @(negedge clk); rst = 0;
        @(negedge clk);
        checks++; if (ACC !== 9'd0 || Done !== 1'b0) begin fails++; $display("FAIL idle_after_reset: acc %0d done %b want 0 0", ACC, Done); end
    endtask

    task automatic test_basic;
        int lat; logic [8:0] acc; logic da;
        mult_run(4'd2, 4'd2, lat, acc, da);
        checks++; if (lat !== 9) begin fails++; $display("FAIL t1_latency: got %0d edges want 9", lat); end
        checks++; if (acc !== 9'd4) begin fails++; $display("FAIL t1_acc: got %0d want 4", acc); end
        checks++; if (da !== 1'b0) begin fails++; $display("FAIL t1_done_width: got %b want 0", da); end
        @(negedge clk); @(negedge clk);
        checks++; if (ACC !== 9'd4 || Done !== 1'b0) begin fails++; $display("FAIL t1_hold: acc %0d done %b want 4 0", ACC, Done); end
    endtask

    task automatic test_max;
        int lat; logic [8:0] acc; logic da;
        mult_run(4'd15, 4'd15, lat, acc, da);
        checks++; if (acc !== 9'b0_1110_0001) begin fails++; $display("FAIL t2_acc: got %0d want 225", acc); end
        checks++; if (da !== 1'b0 || lat !== 9) begin fails++; $display("FAIL t2_done_width: done_after %b lat %0d want 0 9", da, lat); end
    endtask

    task automatic test_sweep;
        int lat; logic [8:0] acc; logic da;
        mult_run(4'd0, 4'd13, lat, acc, da);
        checks++; if (acc !== 9'd0) begin fails++; $display("FAIL t3_zero: got %0d want 0", acc); end
        mult_run(4'd13, 4'd11, lat, acc, da);
        checks++; if (acc !== 9'd143) begin fails++; $display("FAIL t3_13x11: got %0d want 143", acc); end
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                mult_run(4'(a), 4'(b), lat, acc, da);
                checks++;
                if (acc !== 9'(a * b) || lat !== 9 || da !== 1'b0) begin
                    fails++;
                    $display("FAIL sweep_%0dx%0d: acc %0d lat %0d done_after %b want %0d 9 0", a, b, acc, lat, da, a * b);
                end
            end
    endtask

    task automatic test_back_to_back;
        int gap;
        Mplier = 4'd3; Mcand = 4'd5; St = 1;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!Done && gap < 30);
        checks++; if (ACC !== 9'd15 || Done !== 1'b1) begin fails++; $display("FAIL t4_first: acc %0d done %b want 15 1", ACC, Done); end
        Mplier = 4'd7; Mcand = 4'd9;
        gap = 0;
        do begin @(negedge clk); gap++; end while (!Done && gap < 30);
        checks++; if (gap !== 10) begin fails++; $display("FAIL t4_gap: got %0d cycles want 10", gap); end
        checks++; if (ACC !== 9'd63) begin fails++; $display("FAIL t4_second: got %0d want 63", ACC); end
        St = 0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_ignore_busy;
        int lat; int extra;
        Mplier = 4'd6; Mcand = 4'd7; St = 1;
        @(negedge clk); lat = 1; St = 0;
        Mcand = 4'd1; Mplier = 4'd15;
        @(negedge clk); lat++; St = 1;
        @(negedge clk); lat++;
        @(negedge clk); lat++;
        @(negedge clk); lat++; St = 0;
        while (!Done && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (ACC !== 9'd42 || lat !== 9) begin fails++; $display("FAIL t5_acc: acc %0d lat %0d want 42 9", ACC, lat); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (Done) extra++; end
        checks++; if (extra !== 0) begin fails++; $display("FAIL t5_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_async_reset;
        int lat; logic [8:0] acc; logic da;
        Mplier = 4'd11; Mcand = 4'd6; St = 1;
        @(negedge clk); St = 0;
        repeat (4) @(negedge clk);
        #2 rst = 1;
        #1;
        checks++; if (ACC !== 9'd0 || Done !== 1'b0) begin fails++; $display("FAIL t6_async: acc %0d done %b want 0 0", ACC, Done); end
        @(negedge clk); rst = 0;
        @(negedge clk);
        mult_run(4'd9, 4'd9, lat, acc, da);
        checks++; if (acc !== 9'd81 || lat !== 9) begin fails++; $display("FAIL t6_restart: acc %0d lat %0d want 81 9", acc, lat); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_sweep;
        test_back_to_back;
        test_ignore_busy;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
